// File: rtl/eth_mii_rx.sv
// MII receive front end: preamble/SFD strip, byte assembly, framing status and counters.
// Optional FCS check is built when ETH_RX_CRC_CHK_EN is defined.
module eth_mii_rx #(
    parameter int MIN_PRE = 6,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mii_rxd,
    input  logic        mii_rxdv,
    input  logic        mii_rxer,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] out_len,
    output logic [3:0]  out_status,
    input  logic        cnt_clr,
    output logic [15:0] frm_ok_cnt,
    output logic [15:0] frm_err_cnt
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_rxd;
    logic        r_rxdv;
    logic        r_rxer;
    logic [7:0]  r_pre_cnt;
    logic [15:0] r_bytes;
    logic        r_phase;
    logic [3:0]  r_lo;
    logic [7:0]  r_hold;
    logic        r_err_seen;

    logic        w_sfd;
    logic        w_byte_done;
    logic        w_close;
    logic        w_trunc;
    logic        w_eof;
    logic        w_emit;
    logic        w_frame_end;
    logic        w_frame_ok;
    logic        w_fcs_bad;
    logic [3:0]  w_status;
    logic [7:0]  w_byte;

    // Input pipeline is not reset so WAIT_IDLE sees the true pin level
    always_ff @(posedge clk) begin
        r_rxd  <= mii_rxd;
        r_rxdv <= mii_rxdv;
        r_rxer <= mii_rxer;
    end

`ifdef ETH_RX_CRC_CHK_EN
    logic [31:0] r_crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = x[31-i];
        return r;
    endfunction

    assign w_fcs_bad = rev32(crc_byte(r_crc, r_hold)) != 32'hC704DD7B;

    always_ff @(posedge clk) begin
        if (rst)
            r_crc <= 32'hFFFFFFFF;
        else if (w_sfd)
            r_crc <= 32'hFFFFFFFF;
        else if (w_emit && !w_eof)
            r_crc <= crc_byte(r_crc, r_hold);
    end
`else
    assign w_fcs_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_WAIT_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_sfd       = 1'b0;
        w_byte_done = 1'b0;
        w_close     = 1'b0;
        w_trunc     = 1'b0;
        unique case (r_state)
            S_WAIT_IDLE: if (!r_rxdv) w_next = S_IDLE;
            S_IDLE: begin
                if (r_rxdv)
                    w_next = (r_rxd == 4'h5) ? S_PRE : S_DROP;
            end
            S_PRE: begin
                if (!r_rxdv)
                    w_next = S_IDLE;
                else if (r_rxd == 4'h5)
                    w_next = S_PRE;
                else if (r_rxd == 4'hD && r_pre_cnt >= 8'(MIN_PRE)) begin
                    w_next = S_DATA;
                    w_sfd  = 1'b1;
                end else
                    w_next = S_DROP;
            end
            S_DATA: begin
                if (!r_rxdv) begin
                    w_next  = S_IDLE;
                    w_close = 1'b1;
                end else if (r_phase) begin
                    w_byte_done = 1'b1;
                    if (r_bytes == 16'(MAX_LEN)) begin
                        w_trunc = 1'b1;
                        w_next  = S_DROP;
                    end
                end
            end
            S_DROP: if (!r_rxdv) w_next = S_IDLE;
            default: w_next = S_WAIT_IDLE;
        endcase
    end

    assign w_byte      = {r_rxd, r_lo};
    assign w_eof       = (w_close && r_bytes != 16'd0) || w_trunc;
    assign w_emit      = w_eof || (w_byte_done && r_bytes != 16'd0);
    assign w_frame_end = w_eof || (w_close && r_bytes == 16'd0);
    assign w_status[0] = r_err_seen | r_rxer;
    assign w_status[1] = w_close & r_phase;
    assign w_status[2] = w_trunc | (r_bytes < 16'(MIN_LEN));
    assign w_status[3] = w_fcs_bad;
    assign w_frame_ok  = w_eof && (w_status == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_len    <= 16'd0;
            out_status <= 4'd0;
            r_pre_cnt  <= 8'd0;
            r_bytes    <= 16'd0;
            r_phase    <= 1'b0;
            r_lo       <= 4'd0;
            r_hold     <= 8'd0;
            r_err_seen <= 1'b0;
        end else begin
            out_valid <= w_emit;
            out_sof   <= w_emit && r_bytes == 16'd1;
            out_eof   <= w_eof;
            if (w_emit)
                out_data <= r_hold;
            if (w_eof) begin
                out_len    <= r_bytes;
                out_status <= w_status;
            end
            if (r_state != S_PRE)
                r_pre_cnt <= 8'd1;
            else if (r_rxd == 4'h5 && r_pre_cnt != 8'hFF)
                r_pre_cnt <= r_pre_cnt + 8'd1;
            if (w_sfd) begin
                r_bytes    <= 16'd0;
                r_phase    <= 1'b0;
                r_err_seen <= r_rxer;
            end else if (r_state == S_DATA) begin
                r_err_seen <= r_err_seen | r_rxer;
                if (r_rxdv) begin
                    r_phase <= ~r_phase;
                    if (!r_phase)
                        r_lo <= r_rxd;
                end
                if (w_byte_done && !w_trunc) begin
                    r_hold  <= w_byte;
                    r_bytes <= r_bytes + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            frm_ok_cnt  <= 16'd0;
            frm_err_cnt <= 16'd0;
        end else if (w_frame_end) begin
            if (w_frame_ok) begin
                if (frm_ok_cnt != 16'hFFFF)
                    frm_ok_cnt <= frm_ok_cnt + 16'd1;
            end else if (frm_err_cnt != 16'hFFFF)
                frm_err_cnt <= frm_err_cnt + 16'd1;
        end
    end

endmodule
